// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - load handshake, control and status bundle for countdown_timer
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count_out;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_value, start, pause, abort,
    input  load_ready, count_out, busy, done
  );

  modport slave (
    input  load_valid, load_value, start, pause, abort,
    output load_ready, count_out, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with start/pause/abort and one-cycle done pulse
// Optional COUNTDOWN_TIMER_AUTO_RELOAD_EN: terminal count reloads the last loaded value and keeps running.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  countdown_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             load_acc;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign bus.load_ready = (state_q == IDLE) || (state_q == ARMED);
  assign bus.busy       = (state_q == RUN);
  assign bus.count_out  = count_q;
  assign bus.done       = done_q;
  assign load_acc       = bus.load_valid && bus.load_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    // abort outranks every other request in the same cycle
    if (bus.abort) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load_acc) begin
            count_d = bus.load_value;
            state_d = ARMED;
          end
        end
        ARMED: begin
          if (load_acc) begin
            count_d = bus.load_value;
          end else if (bus.start) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (!bus.pause) begin
            // <= 1 so a loaded 0 terminates without wrapping
            if (count_q <= WIDTH'(1)) begin
              done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = IDLE;
`endif
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      if (load_acc) reload_d = bus.load_value;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed and randomized checks of countdown_timer against a behavioural model
module tb_countdown_timer;
  localparam int W = 4;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  localparam bit RELOAD = 1'b1;
`else
  localparam bit RELOAD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  countdown_timer_if #(.WIDTH(W)) bus ();
  countdown_timer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: "phase" is idle/armed/running, "left" is the remaining count.
  bit model_ok = 1'b0;
  int phase = 0;
  int left = 0;
  int rel = 0;
  bit m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0; left = 0; rel = 0; m_done = 1'b0; model_ok = 1'b1;
    end else begin
      m_done = 1'b0;
      if (bus.abort) begin
        phase = 0; left = 0;
      end else if (phase == 2) begin
        if (!bus.pause) begin
          if (left == 0 || left == 1) begin
            m_done = 1'b1;
            if (RELOAD) left = rel;
            else begin left = 0; phase = 0; end
          end else left = left - 1;
        end
      end else if (bus.load_valid) begin
        left = int'(bus.load_value); rel = left; phase = 1;
      end else if (phase == 1 && bus.start) begin
        phase = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("cyc_count", int'(bus.count_out), left);
      chk("cyc_busy", int'(bus.busy), int'(phase == 2));
      chk("cyc_done", int'(bus.done), int'(m_done));
      chk("cyc_ready", int'(bus.load_ready), int'(phase != 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int v);
    bus.load_valid = 1'b1;
    bus.load_value = W'(v);
    tick();
    bus.load_valid = 1'b0;
    chk("load_count", int'(bus.count_out), v);
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic run_lat(input string nm, input int v, input int p_at, input int p_n, input int exp_lat);
    int got;
    got = -1;
    do_load(v);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({nm, "_busy"}, int'(bus.busy), 1);
    for (int c = 1; c <= 40; c++) begin
      bus.pause = (c > p_at) && (c <= p_at + p_n);
      tick();
      if (bus.done) begin
        got = c;
        break;
      end
    end
    bus.pause = 1'b0;
    chk({nm, "_latency"}, got, exp_lat);
    chk({nm, "_endcount"}, int'(bus.count_out), RELOAD ? v : 0);
    do_abort();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn_q[$];
    bus.load_valid = 1'b0;
    bus.load_value = '0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", int'(bus.count_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_ready", int'(bus.load_ready), 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("idle_start_busy", int'(bus.busy), 0);
    chk("idle_start_ready", int'(bus.load_ready), 1);

    do_load(5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("basic_busy", int'(bus.busy), 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("basic_count", int'(bus.count_out), (k == 5 && RELOAD) ? 5 : 5 - k);
      chk("basic_done", int'(bus.done), int'(k == 5));
      chk("basic_busy_k", int'(bus.busy), int'(k < 5 || RELOAD));
    end
    tick();
    chk("basic_done_clear", int'(bus.done), 0);
    do_abort();

    run_lat("zero", 0, 99, 0, 1);
    run_lat("max", 15, 99, 0, 15);
    run_lat("one", 1, 99, 0, 1);
    run_lat("pause", 4, 1, 3, 7);

    do_load(8);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_value = 4'd3;
    chk("busy_ready", int'(bus.load_ready), 0);
    tick();
    bus.load_valid = 1'b0;
    chk("busy_load_count", int'(bus.count_out), 7);
    tick();
    do_abort();
    chk("abort_count", int'(bus.count_out), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_ready", int'(bus.load_ready), 1);
    tick();
    chk("abort_nodone", int'(bus.done), 0);

    do_load(8);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstrun_count", int'(bus.count_out), 0);
    chk("rstrun_busy", int'(bus.busy), 0);
    chk("rstrun_done", int'(bus.done), 0);
    tick();
    chk("rstrun_nodone", int'(bus.done), 0);

    do_load(2);
    bus.load_valid = 1'b1;
    bus.load_value = 4'd9;
    bus.start = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.start = 1'b0;
    chk("ldstart_count", int'(bus.count_out), 9);
    chk("ldstart_busy", int'(bus.busy), 0);
    tick();
    chk("ldstart_armed", int'(bus.load_ready), 1);
    do_abort();

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    do_load(3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.done) begin
        dn_q.push_back(c);
        chk("ar_reload", int'(bus.count_out), 3);
      end
    end
    chk("ar_pulses", dn_q.size(), 3);
    if (dn_q.size() == 3) begin
      chk("ar_p0", dn_q[0], 3);
      chk("ar_p1", dn_q[1], 6);
      chk("ar_p2", dn_q[2], 9);
    end
    do_abort();
    chk("ar_abort_busy", int'(bus.busy), 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      bus.load_valid = ($urandom_range(0, 2) == 0);
      bus.load_value = W'($urandom);
      bus.start      = ($urandom_range(0, 2) == 0);
      bus.pause      = ($urandom_range(0, 3) == 0);
      bus.abort      = ($urandom_range(0, 39) == 0);
      rst            = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    bus.load_valid = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with a valid/ready load handshake, explicit start and pause controls, and a one-cycle terminal-count pulse. It is the down-counting counterpart to the free-running up counter. It sits beside that counter in the counter block and serves as a programmable delay or timeout for control logic that must wait a known number of cycles.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `load_valid`  input  1  producer offers `load_value`.
- `load_ready`  output  1  timer can accept a load.
- `load_value`  input  WIDTH  initial count, 0 to 2^WIDTH-1.
- `start`  input  1  begin counting from the loaded value.
- `pause`  input  1  freeze the count while running.
- `abort`  input  1  cancel and return to idle.
- `count_out`  output  WIDTH  current count (registered).
- `busy`  output  1  high while in RUN.
- `done`  output  1  registered one-cycle pulse on terminal count.

## Operation
- States: IDLE, ARMED, RUN.
- Load accepted when `load_valid && load_ready` at the edge.
- `load_ready` = (state==IDLE || state==ARMED); combinational from state.
- IDLE:
  - `count_out` holds its last value (0 after reset or abort).
  - Accepted load: `count_out`<=`load_value`, next state ARMED.
  - `start` and `pause` are ignored.
- ARMED:
  - Accepted load: `count_out`<=`load_value`, stay ARMED. Load wins over a same-cycle `start`; that `start` is dropped.
  - Otherwise `start`=1: next state RUN; `count_out` unchanged.
  - `pause` is ignored.
- RUN:
  - `pause`=1: `count_out` frozen, stay RUN, no `done`.
  - Else if `count_out` <= 1: `count_out`<=0, `done`<=1, next state IDLE.
  - Else `count_out`<=`count_out`-1.
  - Loads are refused (`load_ready`=0).
- `abort`=1 in any state: next state IDLE, `count_out`<=0, `done`<=0.
  - Abort beats load, start, pause and terminal count in the same cycle.
- `busy` = (state==RUN).
- `done` is 0 in every cycle not described above.
- Arithmetic: unsigned WIDTH-bit decrement. The count never wraps below 0; a loaded 0 terminates without underflow.

## Timing
- Reset (`rst`=1 at an edge): state IDLE, `count_out`=0, `done`=0, `busy`=0, `load_ready`=1.
  - Reset overrides all inputs.
  - Reset mid-RUN aborts silently with no `done`.
- Load accepted at edge N: `count_out`=V from after edge N.
- `start` sampled at edge M (ARMED): `busy`=1 after M.
  - Count reaches 0 and `done`=1 after edge M+max(V,1), with no pause.
  - On that same edge `busy` falls.
- Each cycle with `pause`=1 in RUN adds exactly one cycle to that latency.
- `done` is high for exactly one cycle, then returns to 0.
- Earliest next load: the cycle in which `done` is high, since `load_ready` is already 1.

## Configuration
- Macro: `COUNTDOWN_TIMER_AUTO_RELOAD_EN`.
- Defined:
  - Every accepted load also writes a WIDTH-bit reload register.
  - At terminal count in RUN: `done`<=1 and `count_out`<=reload; state stays RUN and `busy` stays 1.
  - Resulting `done` period is max(V,1) cycles.
  - Only `abort` or `rst` leaves RUN; the reload register resets to 0.
- Not defined:
  - No reload register.
  - Terminal count always returns to IDLE, as described in Operation.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles, then release. Required: `count_out`=0, `busy`=0, `done`=0, `load_ready`=1; `start` pulsed in IDLE is ignored.
- Basic countdown: load 5, `start` at edge M. Required:
  - `count_out` reads 4,3,2,1,0 after edges M+1..M+5.
  - `done`=1 only in the cycle after M+5.
  - `busy` falls at M+5.
- Edge values:
  - Load 0, then `start`: `done` after M+1, `count_out` stays 0.
  - Load 15, then `start`: `done` after M+15.
  - Load 1, then `start`: `done` after M+1.
- Pause and priority:
  - Load 4, `start`, `pause`=1 for 3 cycles mid-run: `done` after M+7.
  - `load_valid` while `busy`: `load_ready`=0 and the count is unaffected.
  - Load 9 together with `start` in ARMED: `count_out`=9, stays ARMED.
- Abort and reset mid-run: load 8, `start`, then `abort` at M+3. Required: `count_out`=0, IDLE, no `done`. Repeat with `rst` instead of `abort`; same result.
- With `COUNTDOWN_TIMER_AUTO_RELOAD_EN`: load 3, `start`. Required:
  - `done` at M+3, M+6, M+9.
  - `count_out` reloads to 3 on each pulse.
  - `abort` stops it and drives `busy`=0.
